// File: rtl/l15_mem_responder.sv
// l15_mem_responder: stand-in L1.5 serving core L15 requests from a 64-bit word memory.
// Define L15_RESP_ENDIAN_SWAP_EN to byte-swap each 64b word on store writes and returns.
module l15_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4,
  parameter     INIT_FILE = ""
) (
  input  logic         clk_i,
  input  logic         reset_l,
  input  logic         req_val_i,
  input  logic [4:0]   req_rqtype_i,
  input  logic [2:0]   req_size_i,
  input  logic         req_nc_i,
  input  logic         req_threadid_i,
  input  logic [39:0]  req_address_i,
  input  logic [63:0]  req_data_i,
  output logic         req_ack_o,
  output logic         req_header_ack_o,
  output logic         rtrn_val_o,
  input  logic         rtrn_ack_i,
  output logic [3:0]   rtrn_type_o,
  output logic         rtrn_nc_o,
  output logic         rtrn_threadid_o,
  output logic [255:0] rtrn_data_o,
  output logic         err_sticky_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [4:0] RQ_LOAD  = 5'b00000;
  localparam logic [4:0] RQ_STORE = 5'b00001;
  localparam logic [4:0] RQ_IMISS = 5'b10000;
  localparam logic [3:0] RT_LOAD  = 4'b0000;
  localparam logic [3:0] RT_IFILL = 4'b0001;
  localparam logic [3:0] RT_ST    = 4'b0100;
  localparam bit unused_init = (INIT_FILE != "");

  function automatic logic [63:0] swap64(input logic [63:0] d);
`ifdef L15_RESP_ENDIAN_SWAP_EN
    for (int i = 0; i < 8; i++)
      swap64[i*8 +: 8] = d[(7-i)*8 +: 8];
`else
    swap64 = d;
`endif
  endfunction

  logic [63:0]    mem [MEM_WORDS];
  logic [1:0]     state;
  logic [7:0]     cnt;
  logic [4:0]     q_type;
  logic [2:0]     q_size;
  logic [2:0]     q_off;
  logic [AW-1:0]  q_idx;
  logic [63:0]    q_data;

  logic           in_wait;
  logic           fire;
  logic [4:0]     op_type;
  logic [2:0]     op_size;
  logic [2:0]     op_off;
  logic [AW-1:0]  op_idx;
  logic [63:0]    op_data;
  logic [63:0]    wr_data;
  logic           is_ld;
  logic           is_st;
  logic           is_im;
  logic           st_ok;
  logic [7:0]     lanes;
  logic [7:0]     be;
  logic [3:0]     ret_type;
  logic [255:0]   rd_data;
  logic           unused_addr;

  assign unused_addr = ^req_address_i[39:AW+3];

  assign req_ack_o        = reset_l && (state == S_IDLE) && req_val_i;
  assign req_header_ack_o = req_ack_o;

  // With LATENCY==1 the op fires on the capture edge from the live request.
  assign in_wait = (state == S_WAIT);
  assign fire    = in_wait ? (cnt == 8'd1)
                           : (req_ack_o && (LATENCY == 1));
  assign op_type = in_wait ? q_type : req_rqtype_i;
  assign op_size = in_wait ? q_size : req_size_i;
  assign op_off  = in_wait ? q_off  : req_address_i[2:0];
  assign op_idx  = in_wait ? q_idx  : req_address_i[3 +: AW];
  assign op_data = in_wait ? q_data : req_data_i;
  assign wr_data = swap64(op_data);

  always_comb begin
    is_ld = (op_type == RQ_LOAD);
    is_st = (op_type == RQ_STORE);
    is_im = (op_type == RQ_IMISS);
    lanes = 8'h00;
    st_ok = 1'b0;
    unique case (op_size)
      3'd0: begin lanes = 8'h01; st_ok = 1'b1; end
      3'd1: begin lanes = 8'h03; st_ok = ~op_off[0]; end
      3'd2: begin lanes = 8'h0f; st_ok = (op_off[1:0] == 2'b00); end
      3'd3: begin lanes = 8'hff; st_ok = (op_off == 3'd0); end
      default: begin lanes = 8'h00; st_ok = 1'b0; end
    endcase
    be = lanes << op_off;
    ret_type = RT_ST;
    rd_data  = '0;
    unique case (1'b1)
      is_ld: begin
        ret_type = RT_LOAD;
        rd_data  = {128'h0,
                    swap64(mem[{op_idx[AW-1:1], 1'b1}]),
                    swap64(mem[{op_idx[AW-1:1], 1'b0}])};
      end
      is_im: begin
        ret_type = RT_IFILL;
        rd_data  = {swap64(mem[{op_idx[AW-1:2], 2'd3}]),
                    swap64(mem[{op_idx[AW-1:2], 2'd2}]),
                    swap64(mem[{op_idx[AW-1:2], 2'd1}]),
                    swap64(mem[{op_idx[AW-1:2], 2'd0}])};
      end
      default: begin
        ret_type = RT_ST;
        rd_data  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (fire && is_st && st_ok) begin
      for (int b = 0; b < 8; b++)
        if (be[b])
          mem[op_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state           <= S_IDLE;
      cnt             <= '0;
      q_type          <= '0;
      q_size          <= '0;
      q_off           <= '0;
      q_idx           <= '0;
      q_data          <= '0;
      rtrn_val_o      <= 1'b0;
      rtrn_type_o     <= '0;
      rtrn_nc_o       <= 1'b0;
      rtrn_threadid_o <= 1'b0;
      rtrn_data_o     <= '0;
      err_sticky_o    <= 1'b0;
    end else begin
      if (fire) begin
        rtrn_type_o  <= ret_type;
        rtrn_data_o  <= rd_data;
        err_sticky_o <= err_sticky_o
                      | ~(is_ld | is_st | is_im)
                      | (is_st & ~st_ok);
      end
      unique case (state)
        S_IDLE: begin
          if (req_ack_o) begin
            q_type          <= req_rqtype_i;
            q_size          <= req_size_i;
            q_off           <= req_address_i[2:0];
            q_idx           <= req_address_i[3 +: AW];
            q_data          <= req_data_i;
            rtrn_nc_o       <= req_nc_i;
            rtrn_threadid_o <= req_threadid_i;
            cnt             <= 8'(LATENCY - 1);
            if (fire) begin
              state      <= S_RESP;
              rtrn_val_o <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 8'd1;
          if (fire) begin
            state      <= S_RESP;
            rtrn_val_o <= 1'b1;
          end
        end
        S_RESP: begin
          if (rtrn_ack_i) begin
            rtrn_val_o <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l15_mem_responder.sv
// tb_l15_mem_responder: directed bench for l15_mem_responder.
// Main instance LATENCY=4, second instance LATENCY=1 for the latency check.
module tb_l15_mem_responder;

  localparam logic [4:0] LD = 5'b00000;
  localparam logic [4:0] ST = 5'b00001;
  localparam logic [4:0] IM = 5'b10000;
  localparam logic [3:0] RT_LOAD  = 4'b0000;
  localparam logic [3:0] RT_IFILL = 4'b0001;
  localparam logic [3:0] RT_ST    = 4'b0100;

  logic         clk_i = 1'b0;
  logic         reset_l;
  logic         req_val_i, req_val_b;
  logic [4:0]   req_rqtype_i;
  logic [2:0]   req_size_i;
  logic         req_nc_i, req_threadid_i;
  logic [39:0]  req_address_i;
  logic [63:0]  req_data_i;
  logic         rtrn_ack_i, rtrn_ack_b;
  logic         req_ack_o, req_header_ack_o, rtrn_val_o;
  logic [3:0]   rtrn_type_o;
  logic         rtrn_nc_o, rtrn_threadid_o, err_sticky_o;
  logic [255:0] rtrn_data_o;
  logic         ack_b, hack_b, rv_b, rnc_b, rtid_b, err_b;
  logic [3:0]   rt_b;
  logic [255:0] rd_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [63:0] w100, w108;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  l15_mem_responder #(.MEM_WORDS(1024), .LATENCY(4)) dut (
    .clk_i(clk_i), .reset_l(reset_l),
    .req_val_i(req_val_i), .req_rqtype_i(req_rqtype_i),
    .req_size_i(req_size_i), .req_nc_i(req_nc_i),
    .req_threadid_i(req_threadid_i), .req_address_i(req_address_i),
    .req_data_i(req_data_i), .req_ack_o(req_ack_o),
    .req_header_ack_o(req_header_ack_o), .rtrn_val_o(rtrn_val_o),
    .rtrn_ack_i(rtrn_ack_i), .rtrn_type_o(rtrn_type_o),
    .rtrn_nc_o(rtrn_nc_o), .rtrn_threadid_o(rtrn_threadid_o),
    .rtrn_data_o(rtrn_data_o), .err_sticky_o(err_sticky_o)
  );

  l15_mem_responder #(.MEM_WORDS(16), .LATENCY(1)) dut_b (
    .clk_i(clk_i), .reset_l(reset_l),
    .req_val_i(req_val_b), .req_rqtype_i(req_rqtype_i),
    .req_size_i(req_size_i), .req_nc_i(req_nc_i),
    .req_threadid_i(req_threadid_i), .req_address_i(req_address_i),
    .req_data_i(req_data_i), .req_ack_o(ack_b),
    .req_header_ack_o(hack_b), .rtrn_val_o(rv_b),
    .rtrn_ack_i(rtrn_ack_b), .rtrn_type_o(rt_b),
    .rtrn_nc_o(rnc_b), .rtrn_threadid_o(rtid_b),
    .rtrn_data_o(rd_b), .err_sticky_o(err_b)
  );

  task automatic do_reset;
    @(negedge clk_i);
    reset_l = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_l = 1'b1;
  endtask

  task automatic issue(input logic [4:0] t, input logic [2:0] sz,
                       input logic [39:0] a, input logic [63:0] d,
                       output int ack_cyc);
    bit got = 1'b0;
    ack_cyc = 0;
    @(negedge clk_i);
    req_val_i = 1'b1;
    req_rqtype_i = t;
    req_size_i = sz;
    req_address_i = a;
    req_data_i = d;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ack_o === 1'b1) begin
        got = 1'b1;
        ack_cyc = cyc;
        break;
      end
      @(negedge clk_i);
    end
    checks++;
    if (!got || req_header_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_ack rq=%b: ack=%b hdr=%b required 1", t,
               req_ack_o, req_header_ack_o);
    end
    @(posedge clk_i);
    #1 req_val_i = 1'b0;
  endtask

  task automatic get_resp(input string nm, input logic [3:0] et,
                          input logic [255:0] ed, output int val_cyc);
    bit got = 1'b0;
    val_cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (rtrn_val_o === 1'b1) begin
        got = 1'b1;
        val_cyc = cyc;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_val: rtrn_val_o never rose, required 1", nm);
    end else begin
      checks++;
      if (rtrn_type_o !== et) begin
        errors++;
        $display("FAIL %s_type: got %b required %b", nm, rtrn_type_o, et);
      end
      checks++;
      if (rtrn_data_o !== ed) begin
        errors++;
        $display("FAIL %s_data: got %h required %h", nm, rtrn_data_o, ed);
      end
      rtrn_ack_i = 1'b1;
      @(posedge clk_i);
      #1 rtrn_ack_i = 1'b0;
      checks++;
      if (rtrn_val_o !== 1'b0) begin
        errors++;
        $display("FAIL %s_drop: rtrn_val_o=%b required 0", nm, rtrn_val_o);
      end
    end
  endtask

  task automatic test_reset;
    req_val_i = 1'b1;
    #3;
    checks++;
    if (req_ack_o !== 1'b0 || req_header_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: ack=%b hdr=%b required 0", req_ack_o,
               req_header_ack_o);
    end
    checks++;
    if ({rtrn_val_o, rtrn_type_o, rtrn_nc_o, rtrn_threadid_o,
         err_sticky_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctl: val=%b type=%b nc=%b tid=%b err=%b required 0",
               rtrn_val_o, rtrn_type_o, rtrn_nc_o, rtrn_threadid_o,
               err_sticky_o);
    end
    checks++;
    if (rtrn_data_o !== 256'h0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", rtrn_data_o);
    end
    req_val_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_l = 1'b1;
  endtask

  task automatic test_store_load;
    int a, v;
    w100 = 64'h1122334455667788;
    w108 = 64'hCAFEBABEDEADBEEF;
    issue(ST, 3'd3, 40'h100, w100, a);
    get_resp("st100", RT_ST, 256'h0, v);
    issue(ST, 3'd3, 40'h108, w108, a);
    get_resp("st108", RT_ST, 256'h0, v);
    req_nc_i = 1'b1;
    req_threadid_i = 1'b1;
    issue(LD, 3'd0, 40'h100, 64'h0, a);
    checks++;
    if (rtrn_nc_o !== 1'b1 || rtrn_threadid_o !== 1'b1) begin
      errors++;
      $display("FAIL echo: nc=%b tid=%b required 1 1", rtrn_nc_o,
               rtrn_threadid_o);
    end
    get_resp("ld100", RT_LOAD, {128'h0, w108, w100}, v);
    req_nc_i = 1'b0;
    req_threadid_i = 1'b0;
    issue(LD, 3'd0, 40'h108, 64'h0, a);
    get_resp("ld108", RT_LOAD, {128'h0, w108, w100}, v);
  endtask

  task automatic test_latency;
    int a, v, ab, vb;
    bit got = 1'b0;
    issue(ST, 3'd3, 40'h200, 64'h0123456789ABCDEF, a);
    get_resp("lat4", RT_ST, 256'h0, v);
    checks++;
    if (v - a !== 4) begin
      errors++;
      $display("FAIL latency4: got %0d cycles required 4", v - a);
    end
    @(negedge clk_i);
    req_rqtype_i = ST;
    req_size_i = 3'd3;
    req_address_i = 40'h0;
    req_data_i = 64'h5;
    req_val_b = 1'b1;
    #1;
    ab = cyc;
    checks++;
    if (ack_b !== 1'b1) begin
      errors++;
      $display("FAIL latency1_ack: ack=%b required 1", ack_b);
    end
    @(posedge clk_i);
    #1 req_val_b = 1'b0;
    vb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (rv_b === 1'b1) begin
        got = 1'b1;
        vb = cyc;
        break;
      end
    end
    checks++;
    if (!got || vb - ab !== 1) begin
      errors++;
      $display("FAIL latency1: got %0d cycles (seen=%b) required 1",
               vb - ab, got);
    end
    rtrn_ack_b = 1'b1;
    @(posedge clk_i);
    #1 rtrn_ack_b = 1'b0;
  endtask

  task automatic test_hold;
    int a, v;
    bit got = 1'b0;
    int bad = 0;
    logic [255:0] exp;
    exp = {128'h0, w108, w100};
    issue(LD, 3'd0, 40'h100, 64'h0, a);
    @(negedge clk_i);
    req_val_i = 1'b1;
    req_address_i = 40'h108;
    for (int i = 0; i < 20; i++) begin
      if (rtrn_val_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rtrn_val_o !== 1'b1 || rtrn_data_o !== exp || req_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: val=%b ack=%b data=%h required 1 0 %h",
                 i, rtrn_val_o, req_ack_o, rtrn_data_o, exp);
      end
      @(negedge clk_i);
    end
    rtrn_ack_i = 1'b1;
    #1;
    checks++;
    if (req_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_ack_same_cycle: ack=%b required 0", req_ack_o);
    end
    @(posedge clk_i);
    #1 rtrn_ack_i = 1'b0;
    checks++;
    if (rtrn_val_o !== 1'b0 || req_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: val=%b ack=%b required 0 1", rtrn_val_o,
               req_ack_o);
    end
    @(posedge clk_i);
    #1 req_val_i = 1'b0;
    get_resp("hold_next", RT_LOAD, exp, v);
  endtask

  task automatic test_byte_store;
    int a, v;
    issue(ST, 3'd0, 40'h103, 64'hAB << 24, a);
    get_resp("st_b", RT_ST, 256'h0, v);
    w100 = 64'h11223344AB667788;
    issue(ST, 3'd1, 40'h10A, 64'h1234 << 16, a);
    get_resp("st_h", RT_ST, 256'h0, v);
    w108 = 64'hCAFEBABE1234BEEF;
    issue(LD, 3'd0, 40'h100, 64'h0, a);
    get_resp("ld_bytes", RT_LOAD, {128'h0, w108, w100}, v);
    checks++;
    if (err_sticky_o !== 1'b0) begin
      errors++;
      $display("FAIL err_aligned: got %b required 0", err_sticky_o);
    end
    issue(ST, 3'd3, 40'h104, 64'hFFFFFFFFFFFFFFFF, a);
    get_resp("st_mis", RT_ST, 256'h0, v);
    checks++;
    if (err_sticky_o !== 1'b1) begin
      errors++;
      $display("FAIL err_misaligned: got %b required 1", err_sticky_o);
    end
    issue(LD, 3'd0, 40'h100, 64'h0, a);
    get_resp("ld_after_mis", RT_LOAD, {128'h0, w108, w100}, v);
  endtask

  task automatic test_imiss;
    int a, v;
    logic [63:0] iw [4];
    for (int i = 0; i < 4; i++) begin
      iw[i] = 64'h0101010101010101 * (i + 1);
      issue(ST, 3'd3, 40'h120 + 40'(i * 8), iw[i], a);
      get_resp("st_im", RT_ST, 256'h0, v);
    end
    issue(IM, 3'd0, 40'h12C, 64'h0, a);
    get_resp("imiss", RT_IFILL, {iw[3], iw[2], iw[1], iw[0]}, v);
    issue(LD, 3'd0, 40'h2100, 64'h0, a);
    get_resp("ld_alias", RT_LOAD, {128'h0, w108, w100}, v);
  endtask

  task automatic test_unsupported;
    int a, v;
    do_reset();
    checks++;
    if (err_sticky_o !== 1'b0) begin
      errors++;
      $display("FAIL unsup_pre: err=%b required 0", err_sticky_o);
    end
    issue(5'b00100, 3'd3, 40'h100, 64'hFFFFFFFFFFFFFFFF, a);
    get_resp("unsup", RT_ST, 256'h0, v);
    checks++;
    if (err_sticky_o !== 1'b1) begin
      errors++;
      $display("FAIL unsup_err: err=%b required 1", err_sticky_o);
    end
    issue(LD, 3'd0, 40'h100, 64'h0, a);
    get_resp("unsup_mem", RT_LOAD, {128'h0, w108, w100}, v);
    checks++;
    if (err_sticky_o !== 1'b1) begin
      errors++;
      $display("FAIL unsup_sticky: err=%b required 1", err_sticky_o);
    end
    @(negedge clk_i);
    reset_l = 1'b0;
    #1;
    checks++;
    if (err_sticky_o !== 1'b0) begin
      errors++;
      $display("FAIL unsup_clear: err=%b required 0", err_sticky_o);
    end
    @(negedge clk_i);
    reset_l = 1'b1;
  endtask

  task automatic test_reset_mid;
    int a, v;
    int bad = 0;
    issue(ST, 3'd3, 40'h100, 64'hDEADDEADDEADDEAD, a);
    @(negedge clk_i);
    @(negedge clk_i);
    #2 reset_l = 1'b0;
    #1;
    checks++;
    if ({rtrn_val_o, rtrn_type_o, rtrn_nc_o, rtrn_threadid_o, err_sticky_o,
         req_ack_o, req_header_ack_o} !== 10'h0 || rtrn_data_o !== 256'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: val=%b type=%b err=%b data=%h required 0",
               rtrn_val_o, rtrn_type_o, err_sticky_o, rtrn_data_o);
    end
    @(negedge clk_i);
    reset_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (rtrn_val_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_noreturn: rtrn_val_o high %0d cycles required 0",
               bad);
    end
    issue(LD, 3'd0, 40'h100, 64'h0, a);
    get_resp("mid_reset_ld", RT_LOAD, {128'h0, w108, w100}, v);
  endtask

  initial begin
    reset_l = 1'b0;
    req_val_i = 1'b0;
    req_val_b = 1'b0;
    req_rqtype_i = '0;
    req_size_i = '0;
    req_nc_i = 1'b0;
    req_threadid_i = 1'b0;
    req_address_i = '0;
    req_data_i = '0;
    rtrn_ack_i = 1'b0;
    rtrn_ack_b = 1'b0;
    w100 = '0;
    w108 = '0;
    test_reset();
    test_store_load();
    test_latency();
    test_hold();
    test_byte_store();
    test_imiss();
    test_unsupported();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
